// File: rtl/rcv_pkg.sv
// rtl/rcv_pkg.sv - shared types and width helpers for the serial receive controller
package rcv_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      LOAD  = 3'd4
   } rcv_state_t;

   function automatic int timer_width(input int clks_per_bit);
      return $clog2(clks_per_bit);
   endfunction

   // One extra count so bit_cnt can hold DATA_BITS itself after the last strobe.
   function automatic int bit_cnt_width(input int data_bits);
      return $clog2(data_bits + 1);
   endfunction

endpackage

// File: rtl/rcv_timer.sv
// rtl/rcv_timer.sv - bit-period counter with clear, enable and registered terminal-count pulse
module rcv_timer
   import rcv_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10,
   localparam int TW = timer_width(CLKS_PER_BIT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [TW-1:0] count,
   output logic          tc
);

   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] PRE  = TW'(CLKS_PER_BIT - 2);

   // tc is registered from the pre-terminal value so it is high exactly while count == LAST.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         tc    <= 1'b0;
      end else if (clr) begin
         count <= '0;
         tc    <= 1'b0;
      end else if (en) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
         tc    <= (count == PRE);
      end else begin
         tc    <= 1'b0;
      end
   end

endmodule

// File: rtl/rcv_ctrl.sv
// rtl/rcv_ctrl.sv - receive control FSM: start detect, bit pacing, stop check and host flags
module rcv_ctrl
   import rcv_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_BITS    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic serial_in,
   input  logic data_read,
   output logic shift_enable,
   output logic load_buffer,
   output logic data_ready,
   output logic framing_error,
   output logic overrun_error,
   output logic rx_busy
);

   localparam int TW = timer_width(CLKS_PER_BIT);
   localparam int CW = bit_cnt_width(DATA_BITS);
   localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] PRE_TC   = TW'(CLKS_PER_BIT - 2);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

   rcv_state_t    state, next_state;
   logic          prev_in;
   logic [CW-1:0] bit_cnt;
   logic [TW-1:0] timer_cnt;
   logic          timer_tc;
   logic          timer_clr;
   logic          timer_en;
   logic          start_edge;

   assign start_edge = (state == IDLE) && prev_in && !serial_in;
   assign timer_en   = (state == START) || (state == DATA) || (state == STOP);

   rcv_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clr   (timer_clr),
      .en    (timer_en),
      .count (timer_cnt),
      .tc    (timer_tc)
   );

   always_comb begin
      next_state = state;
      timer_clr  = 1'b0;
      case (state)
         IDLE: begin
            if (start_edge) begin
               next_state = START;
               timer_clr  = 1'b1;
            end
         end
         START: begin
            if (timer_cnt == HALF_M1) begin
               timer_clr  = 1'b1;
               next_state = serial_in ? IDLE : DATA;
            end
         end
         DATA: begin
            if (timer_tc && (bit_cnt == LAST_BIT)) begin
               timer_clr  = 1'b1;
               next_state = STOP;
            end
         end
         STOP: begin
            if (timer_tc) next_state = serial_in ? LOAD : IDLE;
         end
         LOAD:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Strobes are decoded one cycle early so the flops present them in the cycle they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         prev_in       <= 1'b1;
         bit_cnt       <= '0;
         shift_enable  <= 1'b0;
         load_buffer   <= 1'b0;
         data_ready    <= 1'b0;
         framing_error <= 1'b0;
         overrun_error <= 1'b0;
         rx_busy       <= 1'b0;
      end else begin
         state        <= next_state;
         prev_in      <= serial_in;
         rx_busy      <= (next_state != IDLE);
         load_buffer  <= (next_state == LOAD);
         shift_enable <= (state == DATA) && (timer_cnt == PRE_TC);

         if ((state == START) && (next_state == DATA))
            bit_cnt <= '0;
         else if ((state == DATA) && timer_tc)
            bit_cnt <= bit_cnt + 1'b1;

         if (start_edge)
            framing_error <= 1'b0;
         else if ((state == STOP) && timer_tc && !serial_in)
            framing_error <= 1'b1;

         // A load beats a coincident host read; a read still cancels the overrun.
         if (state == LOAD) begin
            data_ready <= 1'b1;
            if (data_read)
               overrun_error <= 1'b0;
            else if (data_ready)
               overrun_error <= 1'b1;
         end else if (data_read) begin
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rcv_ctrl.sv
// tb/tb_rcv_ctrl.sv - directed self-checking bench for rcv_ctrl
module tb_rcv_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic serial_in = 1'b1;
   logic data_read = 1'b0;
   logic shift_enable, load_buffer, data_ready, framing_error, overrun_error, rx_busy;

   int n_chk = 0;
   int n_err = 0;

   int se_cnt, se_first, se_last, se_bad;
   int lb_cnt, lb_cyc, dr_cyc, ov_cyc, fe_cyc, busy_last;
   int dr_at0, fe_at0, fe_at1, rst_outs;

   rcv_ctrl #(.CLKS_PER_BIT(10), .DATA_BITS(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .serial_in     (serial_in),
      .data_read     (data_read),
      .shift_enable  (shift_enable),
      .load_buffer   (load_buffer),
      .data_ready    (data_ready),
      .framing_error (framing_error),
      .overrun_error (overrun_error),
      .rx_busy       (rx_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic line_val(input int cyc, input logic [7:0] d,
                                     input logic stop_b, input bit glitch);
      int b;
      if (glitch) return (cyc < 3) ? 1'b0 : 1'b1;
      if (cyc < 10) return 1'b0;
      b = (cyc - 10) / 10;
      if (b < 8) return d[b];
      if (b == 8) return stop_b;
      return 1'b1;
   endfunction

   // Cycle 0 is the first cycle with the line low; outputs sampled on the falling edge.
   task automatic run(input logic [7:0] d, input logic stop_b, input bit glitch,
                      input int ncyc, input int rd_cyc, input int rst_cyc);
      se_cnt = 0; se_first = -1; se_last = -1; se_bad = 0;
      lb_cnt = 0; lb_cyc = -1; dr_cyc = -1; ov_cyc = -1; fe_cyc = -1; busy_last = -1;
      dr_at0 = -1; fe_at0 = -1; fe_at1 = -1; rst_outs = -1;
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         @(posedge clk);
         #1;
         serial_in = line_val(cyc, d, stop_b, glitch);
         data_read = (cyc == rd_cyc);
         rst       = (cyc == rst_cyc);
         @(negedge clk);
         if (shift_enable) begin
            se_cnt++;
            if (se_first < 0) se_first = cyc;
            se_last = cyc;
            if (!(cyc >= 15 && cyc <= 85 && ((cyc - 15) % 10) == 0)) se_bad++;
         end
         if (load_buffer) begin
            lb_cnt++;
            if (lb_cyc < 0) lb_cyc = cyc;
         end
         if (data_ready && dr_cyc < 0) dr_cyc = cyc;
         if (overrun_error && ov_cyc < 0) ov_cyc = cyc;
         if (framing_error && fe_cyc < 0) fe_cyc = cyc;
         if (rx_busy) busy_last = cyc;
         if (cyc == 0) begin
            dr_at0 = data_ready;
            fe_at0 = framing_error;
         end
         if (cyc == 1) fe_at1 = framing_error;
         if (cyc == rst_cyc)
            rst_outs = {shift_enable, load_buffer, data_ready, framing_error,
                        overrun_error, rx_busy};
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         serial_in = 1'b1;
         data_read = 1'b0;
         rst       = 1'b0;
      end
   endtask

   task automatic host_read(input string tag);
      @(posedge clk);
      #1;
      serial_in = 1'b1;
      rst       = 1'b0;
      data_read = 1'b1;
      @(posedge clk);
      #1;
      data_read = 1'b0;
      @(negedge clk);
      check({tag, "_dr_clr"}, data_ready, 0);
      check({tag, "_ov_clr"}, overrun_error, 0);
   endtask

   task automatic good_frame_checks(input string tag);
      check({tag, "_se_cnt"}, se_cnt, 8);
      check({tag, "_se_first"}, se_first, 15);
      check({tag, "_se_last"}, se_last, 85);
      check({tag, "_se_bad"}, se_bad, 0);
      check({tag, "_lb_cyc"}, lb_cyc, 96);
      check({tag, "_lb_cnt"}, lb_cnt, 1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_se", shift_enable, 0);
      check("rst_lb", load_buffer, 0);
      check("rst_dr", data_ready, 0);
      check("rst_fe", framing_error, 0);
      check("rst_ov", overrun_error, 0);
      check("rst_busy", rx_busy, 0);
      idle(5);

      // valid frame 0xA5
      run(8'hA5, 1'b1, 1'b0, 110, -1, -1);
      good_frame_checks("a5");
      check("a5_dr_cyc", dr_cyc, 97);
      check("a5_busy_last", busy_last, 96);
      check("a5_fe", fe_cyc, -1);
      check("a5_ov", ov_cyc, -1);
      host_read("a5");
      idle(3);

      // 3-cycle glitch
      run(8'h00, 1'b1, 1'b1, 20, -1, -1);
      check("gl_se_cnt", se_cnt, 0);
      check("gl_busy_last", busy_last, 5);
      check("gl_lb_cnt", lb_cnt, 0);
      idle(3);

      // bad stop bit
      run(8'h3C, 1'b0, 1'b0, 110, -1, -1);
      check("bs_se_cnt", se_cnt, 8);
      check("bs_fe_cyc", fe_cyc, 96);
      check("bs_lb_cnt", lb_cnt, 0);
      check("bs_dr", dr_cyc, -1);
      idle(3);

      // two frames back to back without a read
      run(8'h5A, 1'b1, 1'b0, 97, -1, -1);
      check("f1_fe_at0", fe_at0, 1);
      check("f1_fe_at1", fe_at1, 0);
      good_frame_checks("f1");
      run(8'hFF, 1'b1, 1'b0, 110, -1, -1);
      check("f2_dr_at0", dr_at0, 1);
      good_frame_checks("f2");
      check("f2_ov_cyc", ov_cyc, 97);
      host_read("ovr");
      idle(3);

      // read coinciding with the second load
      run(8'h01, 1'b1, 1'b0, 110, -1, -1);
      check("d_dr_cyc", dr_cyc, 97);
      run(8'h80, 1'b1, 1'b0, 110, 96, -1);
      check("e_lb_cyc", lb_cyc, 96);
      check("e_ov", ov_cyc, -1);
      check("e_dr_end", data_ready, 1);
      check("e_ov_end", overrun_error, 0);

      // reset mid-frame while data_ready is still pending
      run(8'h96, 1'b1, 1'b0, 41, -1, 40);
      check("rs_outs", rst_outs, 0);
      check("rs_se_cnt", se_cnt, 3);
      check("rs_lb_cnt", lb_cnt, 0);
      idle(5);
      run(8'hC3, 1'b1, 1'b0, 110, -1, -1);
      good_frame_checks("c3");
      check("c3_dr_cyc", dr_cyc, 97);
      check("c3_fe", fe_cyc, -1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
